// File: rtl/top_soc_pkg.sv
// Shared constants and types for the top_soc AXI4-Lite register block and its engine.
package top_soc_pkg;

  localparam int unsigned AXI_ADDR_W  = 32;
  localparam int unsigned AXI_DATA_W  = 32;
  localparam int unsigned ENG_LATENCY = 4;

  localparam logic [3:0] OFF_CTRL     = 4'h0;
  localparam logic [3:0] OFF_STATUS   = 4'h4;
  localparam logic [3:0] OFF_DATA_IN  = 4'h8;
  localparam logic [3:0] OFF_DATA_OUT = 4'hC;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned STATUS_BUSY_BIT = 0;
  localparam int unsigned STATUS_DONE_BIT = 1;
  localparam int unsigned CTRL_START_BIT  = 0;

  typedef enum logic {
    ENG_IDLE = 1'b0,
    ENG_RUN  = 1'b1
  } eng_state_e;

  // Word-aligned register offset; the byte lane bits carry no meaning here.
  function automatic logic [3:0] reg_offset(input logic [3:0] addr_lo);
    return {addr_lo[3:2], 2'b00};
  endfunction

endpackage

// File: rtl/top_soc_engine.sv
// Fixed-latency engine: on start, latches a word and after LATENCY cycles presents it byte-reversed.
module soc_engine
  import top_soc_pkg::*;
#(
  parameter int unsigned DATA_W  = AXI_DATA_W,
  parameter int unsigned LATENCY = ENG_LATENCY
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_data_out
);

  localparam int unsigned CNT_W = $clog2(LATENCY + 1);

  eng_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic [DATA_W-1:0] r_lat, w_lat_nxt;
  logic [DATA_W-1:0] r_dout, w_dout_nxt;
  logic [DATA_W-1:0] w_rev;

  always_comb begin
    w_rev = '0;
    for (int i = 0; i < int'(DATA_W / 8); i++) begin
      w_rev[8*i +: 8] = r_lat[DATA_W - 8 - 8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ENG_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_lat   <= '0;
      r_dout  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_lat   <= w_lat_nxt;
      r_dout  <= w_dout_nxt;
    end
  end

  // Starts arriving while running fall through the RUN branch and are dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    w_done_nxt  = r_done;
    w_lat_nxt   = r_lat;
    w_dout_nxt  = r_dout;
    case (r_state)
      ENG_IDLE: begin
        if (i_start) begin
          w_state_nxt = ENG_RUN;
          w_cnt_nxt   = CNT_W'(LATENCY);
          w_busy_nxt  = 1'b1;
          w_done_nxt  = 1'b0;
          w_lat_nxt   = i_data;
        end
      end
      ENG_RUN: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = ENG_IDLE;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_dout_nxt  = w_rev;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_nxt = ENG_IDLE;
    endcase
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_data_out = r_dout;

endmodule

// File: rtl/top_soc.sv
// AXI4-Lite slave with CTRL/STATUS/DATA_IN/DATA_OUT registers fronting the byte-reverse engine.
module top_soc
  import top_soc_pkg::*;
#(
  parameter int unsigned ADDR_W  = AXI_ADDR_W,
  parameter int unsigned DATA_W  = AXI_DATA_W,
  parameter int unsigned LATENCY = ENG_LATENCY
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic              WVALID,
  output logic              WREADY,
  input  logic [DATA_W-1:0] WDATA,
  output logic              BVALID,
  input  logic              BREADY,
  output logic [1:0]        BRESP,
  input  logic              ARVALID,
  output logic              ARREADY,
  input  logic [ADDR_W-1:0] ARADDR,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP
);

  logic              r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
  logic [1:0]        r_bresp, r_rresp;
  logic [DATA_W-1:0] r_rdata;
  logic              r_aw_full, r_w_full;
  logic [ADDR_W-1:0] r_awaddr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_data_in;

  logic              w_aw_hs, w_w_hs, w_ar_hs, w_do_write;
  logic [ADDR_W-1:0] w_aw_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_wr_mapped, w_rd_mapped, w_start;
  logic [3:0]        w_wr_off, w_rd_off;
  logic [DATA_W-1:0] w_rd_data;
  logic [1:0]        w_rd_resp;
  logic              w_busy, w_done;
  logic [DATA_W-1:0] w_data_out;
  logic              w_unused_addr_bits;

  assign w_aw_hs = AWVALID && r_awready;
  assign w_w_hs  = WVALID && r_wready;
  assign w_ar_hs = ARVALID && r_arready;

  // A half captured earlier is merged with the live half so the write commits on the later handshake.
  assign w_aw_addr  = r_aw_full ? r_awaddr : AWADDR;
  assign w_wdata    = r_w_full ? r_wdata : WDATA;
  assign w_do_write = (w_aw_hs || r_aw_full) && (w_w_hs || r_w_full) && !r_bvalid;

  assign w_wr_mapped = (w_aw_addr[ADDR_W-1:4] == '0);
  assign w_wr_off    = reg_offset(w_aw_addr[3:0]);
  assign w_rd_mapped = (ARADDR[ADDR_W-1:4] == '0);
  assign w_rd_off    = reg_offset(ARADDR[3:0]);
  assign w_start     = w_do_write && w_wr_mapped && (w_wr_off == OFF_CTRL)
                       && w_wdata[CTRL_START_BIT];

  assign w_unused_addr_bits = &{1'b0, w_aw_addr[1:0], ARADDR[1:0]};

  // Write address/data capture and write response.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_awready <= 1'b1;
      r_wready  <= 1'b1;
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      if (w_do_write) begin
        r_aw_full <= 1'b0;
        r_w_full  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_wr_mapped ? RESP_OKAY : RESP_SLVERR;
      end else begin
        if (w_aw_hs) begin
          r_aw_full <= 1'b1;
          r_awaddr  <= AWADDR;
        end
        if (w_w_hs) begin
          r_w_full <= 1'b1;
          r_wdata  <= WDATA;
        end
      end
      if (w_aw_hs) r_awready <= 1'b0;
      if (w_w_hs)  r_wready  <= 1'b0;
      if (r_bvalid && BREADY) begin
        r_bvalid  <= 1'b0;
        r_awready <= 1'b1;
        r_wready  <= 1'b1;
      end
    end
  end

  // DATA_IN is the only writable storage; CTRL acts through the start pulse.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_data_in <= '0;
    end else if (w_do_write && w_wr_mapped && (w_wr_off == OFF_DATA_IN)) begin
      r_data_in <= w_wdata;
    end
  end

  always_comb begin
    w_rd_data = '0;
    w_rd_resp = RESP_OKAY;
    if (!w_rd_mapped) begin
      w_rd_resp = RESP_SLVERR;
    end else begin
      case (w_rd_off)
        OFF_STATUS: begin
          w_rd_data[STATUS_BUSY_BIT] = w_busy;
          w_rd_data[STATUS_DONE_BIT] = w_done;
        end
        OFF_DATA_IN:  w_rd_data = r_data_in;
        OFF_DATA_OUT: w_rd_data = w_data_out;
        default:      w_rd_data = '0;
      endcase
    end
  end

  // Read data is sampled at the AR handshake and held until accepted.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b1;
      r_rdata   <= w_rd_data;
      r_rresp   <= w_rd_resp;
    end else if (r_rvalid && RREADY) begin
      r_rvalid  <= 1'b0;
      r_arready <= 1'b1;
    end
  end

  soc_engine #(
    .DATA_W  (DATA_W),
    .LATENCY (LATENCY)
  ) u_engine (
    .clk        (ACLK),
    .rst_n      (ARESETN),
    .i_start    (w_start),
    .i_data     (r_data_in),
    .o_busy     (w_busy),
    .o_done     (w_done),
    .o_data_out (w_data_out)
  );

  assign AWREADY = r_awready;
  assign WREADY  = r_wready;
  assign BVALID  = r_bvalid;
  assign BRESP   = r_bresp;
  assign ARREADY = r_arready;
  assign RVALID  = r_rvalid;
  assign RDATA   = r_rdata;
  assign RRESP   = r_rresp;

endmodule

// File: tb/tb_top_soc.sv
// Scoreboard bench for top_soc: expectations are queued as stimulus is driven, compared as responses arrive.
module tb_top_soc;

  localparam int unsigned LAT = 4;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        AWVALID = 1'b0, WVALID = 1'b0, BREADY = 1'b0, ARVALID = 1'b0, RREADY = 1'b0;
  logic [31:0] AWADDR = '0, WDATA = '0, ARADDR = '0;
  logic        AWREADY, WREADY, BVALID, ARREADY, RVALID;
  logic [1:0]  BRESP, RRESP;
  logic [31:0] RDATA;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  logic [1:0]  got_resp;
  logic [31:0] got_data;

  top_soc #(.ADDR_W(32), .DATA_W(32), .LATENCY(LAT)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Bus driver: AW and W together, BREADY held high; returns the observed BRESP.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, output logic [1:0] resp);
    int n;
    bit aw_hs, w_hs, b_hs, got;
    n = 0; got = 0; resp = 2'bxx;
    AWADDR = addr; WDATA = data; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
    while (!got && n < 50) begin
      aw_hs = AWVALID && AWREADY;
      w_hs  = WVALID && WREADY;
      b_hs  = BVALID && BREADY;
      if (b_hs) resp = BRESP;
      tick(); n++;
      if (aw_hs) AWVALID = 1'b0;
      if (w_hs)  WVALID = 1'b0;
      if (b_hs)  got = 1;
    end
    AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    checks++;
    if (!got) begin errors++; $display("FAIL write_timeout addr=%h", addr); end
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    bit ar_hs, r_hs, got;
    n = 0; got = 0; resp = 2'bxx; data = 'x;
    ARADDR = addr; ARVALID = 1'b1; RREADY = 1'b1;
    while (!got && n < 50) begin
      ar_hs = ARVALID && ARREADY;
      r_hs  = RVALID && RREADY;
      if (r_hs) begin data = RDATA; resp = RRESP; end
      tick(); n++;
      if (ar_hs) ARVALID = 1'b0;
      if (r_hs)  got = 1;
    end
    ARVALID = 1'b0; RREADY = 1'b0;
    checks++;
    if (!got) begin errors++; $display("FAIL read_timeout addr=%h", addr); end
  endtask

  task automatic test_reset();
    ARESETN = 1'b0;
    repeat (3) tick();
    checks++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP} !== 9'b111_00_00_00) begin
      errors++;
      $display("FAIL reset_ctrl got=%b exp=%b", {AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP}, 9'b111_00_00_00);
    end
    checks++;
    if (RDATA !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=%h", RDATA, 32'h0); end
    ARESETN = 1'b1;
    tick();
  endtask

  task automatic test_data_reg();
    exp_q.push_back('{32'h0, 2'b00});
    axi_write(32'h8, 32'h1234_5678, got_resp);
    e = exp_q.pop_front();
    checks++;
    if (got_resp !== e.resp) begin errors++; $display("FAIL data_in_bresp got=%b exp=%b", got_resp, e.resp); end
    exp_q.push_back('{32'h1234_5678, 2'b00});
    axi_read(32'h8, got_data, got_resp);
    e = exp_q.pop_front();
    checks++;
    if ({got_data, got_resp} !== {e.data, e.resp}) begin
      errors++; $display("FAIL data_in_read got=%h/%b exp=%h/%b", got_data, got_resp, e.data, e.resp);
    end
  endtask

  // Each entry: read address, expected data, expected response.
  task automatic read_expect(input string name, input logic [31:0] addr, input logic [31:0] d, input logic [1:0] r);
    exp_q.push_back('{d, r});
    axi_read(addr, got_data, got_resp);
    e = exp_q.pop_front();
    checks++;
    if ({got_data, got_resp} !== {e.data, e.resp}) begin
      errors++; $display("FAIL %s got=%h/%b exp=%h/%b", name, got_data, got_resp, e.data, e.resp);
    end
  endtask

  task automatic write_expect(input string name, input logic [31:0] addr, input logic [31:0] d, input logic [1:0] r);
    exp_q.push_back('{32'h0, r});
    axi_write(addr, d, got_resp);
    e = exp_q.pop_front();
    checks++;
    if (got_resp !== e.resp) begin errors++; $display("FAIL %s got=%b exp=%b", name, got_resp, e.resp); end
  endtask

  task automatic test_engine();
    write_expect("eng_start_bresp", 32'h0, 32'h1, 2'b00);
    read_expect("eng_status_busy", 32'h4, 32'h1, 2'b00);
    repeat (LAT + 2) tick();
    read_expect("eng_status_done", 32'h4, 32'h2, 2'b00);
    read_expect("eng_data_out", 32'hC, 32'h7856_3412, 2'b00);
    read_expect("eng_ctrl_selfclr", 32'h0, 32'h0, 2'b00);
  endtask

  // Second start commits two cycles after the first; DONE must still land LAT cycles after the first.
  task automatic test_busy_start();
    write_expect("busy_start1", 32'h0, 32'h1, 2'b00);
    write_expect("busy_start2", 32'h0, 32'h1, 2'b00);
    read_expect("busy_status_pre", 32'h4, 32'h1, 2'b00);
    read_expect("busy_status_done", 32'h4, 32'h2, 2'b00);
    read_expect("busy_data_out", 32'hC, 32'h7856_3412, 2'b00);
  endtask

  task automatic test_unmapped();
    read_expect("unmap_read20", 32'h20, 32'h0, 2'b10);
    read_expect("unmap_read_hi", 32'h1000_0008, 32'h0, 2'b10);
    write_expect("unmap_write40", 32'h40, 32'hFFFF_FFFF, 2'b10);
    write_expect("ro_write_status", 32'h4, 32'hFFFF_FFFF, 2'b00);
    write_expect("ro_write_dout", 32'hC, 32'hFFFF_FFFF, 2'b00);
    read_expect("unmap_keep_din", 32'h8, 32'h1234_5678, 2'b00);
    read_expect("unmap_keep_status", 32'h4, 32'h2, 2'b00);
    read_expect("unmap_keep_dout", 32'hC, 32'h7856_3412, 2'b00);
    read_expect("byte_lane_ignored", 32'hB, 32'h1234_5678, 2'b00);
  endtask

  task automatic test_stall();
    WDATA = 32'hCAFE_F00D; WVALID = 1'b1; BREADY = 1'b0;
    tick();
    WVALID = 1'b0;
    checks++;
    if ({WREADY, BVALID} !== 2'b00) begin errors++; $display("FAIL stall_w_capt got=%b exp=%b", {WREADY, BVALID}, 2'b00); end
    tick();
    read_expect("stall_no_update", 32'h8, 32'h1234_5678, 2'b00);
    exp_q.push_back('{32'h0, 2'b00});
    AWADDR = 32'h8; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    e = exp_q.pop_front();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({BVALID, BRESP, AWREADY, WREADY} !== {1'b1, e.resp, 2'b00}) begin
        errors++; $display("FAIL stall_b_hold%0d got=%b exp=%b", i, {BVALID, BRESP, AWREADY, WREADY}, {1'b1, e.resp, 2'b00});
      end
      tick();
    end
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    checks++;
    if ({BVALID, AWREADY, WREADY} !== 3'b011) begin errors++; $display("FAIL stall_b_done got=%b exp=%b", {BVALID, AWREADY, WREADY}, 3'b011); end
    exp_q.push_back('{32'hCAFE_F00D, 2'b00});
    ARADDR = 32'h8; ARVALID = 1'b1; RREADY = 1'b0;
    tick();
    ARVALID = 1'b0;
    e = exp_q.pop_front();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({RVALID, ARREADY, RDATA, RRESP} !== {2'b10, e.data, e.resp}) begin
        errors++; $display("FAIL stall_r_hold%0d got=%b/%h/%b exp=10/%h/%b", i, {RVALID, ARREADY}, RDATA, RRESP, e.data, e.resp);
      end
      tick();
    end
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    checks++;
    if ({RVALID, ARREADY} !== 2'b01) begin errors++; $display("FAIL stall_r_done got=%b exp=%b", {RVALID, ARREADY}, 2'b01); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    for (int i = 0; i < 6; i++) begin
      d = $urandom;
      write_expect("b2b_write", 32'h8, d, 2'b00);
      read_expect("b2b_read", 32'h8, d, 2'b00);
    end
    // Same-cycle write and read of DATA_IN: the read sees the pre-update value.
    write_expect("same_cyc_setup", 32'h8, 32'hAAAA_0001, 2'b00);
    exp_q.push_back('{32'hAAAA_0001, 2'b00});
    AWADDR = 32'h8; WDATA = 32'hBBBB_0002; ARADDR = 32'h8;
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if ({RVALID, RDATA, BVALID} !== {1'b1, e.data, 1'b1}) begin
      errors++; $display("FAIL same_cyc_read got=%b/%h/%b exp=1/%h/1", RVALID, RDATA, BVALID, e.data);
    end
    BREADY = 1'b1; RREADY = 1'b1;
    tick();
    BREADY = 1'b0; RREADY = 1'b0;
    read_expect("same_cyc_after", 32'h8, 32'hBBBB_0002, 2'b00);
  endtask

  task automatic test_reset_mid();
    write_expect("rst_din", 32'h8, 32'hA5A5_5A5A, 2'b00);
    write_expect("rst_start", 32'h0, 32'h1, 2'b00);
    AWADDR = 32'h8; WDATA = 32'h1; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    checks++;
    if (BVALID !== 1'b1) begin errors++; $display("FAIL rst_b_pending got=%b exp=%b", BVALID, 1'b1); end
    ARESETN = 1'b0;
    tick();
    ARESETN = 1'b1;
    checks++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA} !== {9'b111_00_00_00, 32'h0}) begin
      errors++; $display("FAIL rst_mid_outputs got=%b/%h exp=111000000/0", {AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP}, RDATA);
    end
    tick();
    read_expect("rst_status", 32'h4, 32'h0, 2'b00);
    read_expect("rst_din_cleared", 32'h8, 32'h0, 2'b00);
    read_expect("rst_dout_cleared", 32'hC, 32'h0, 2'b00);
    repeat (LAT + 2) tick();
    read_expect("rst_no_late_done", 32'h4, 32'h0, 2'b00);
  endtask

  initial begin
    test_reset();
    test_data_reg();
    test_engine();
    test_busy_start();
    test_unmapped();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/top_soc.md
# top_soc

AXI4-Lite slave subsystem: a 32-bit AXI-Lite register front end with four memory-mapped registers, plus a small fixed-latency processing engine. The engine byte-reverses a data word. The block is the top-level SoC target driven by the verification environment through the `axi_if` signal bundle; port names match that bundle one-to-one. Only one transaction per channel pair is outstanding; there are no bursts, no WSTRB and no PROT.

## Interface
- `ADDR_W`, 32, AXI address width
- `DATA_W`, 32, AXI data width
- `LATENCY`, 4, engine cycles from start to done (≥1)
- One clock; reset is synchronous and active-low.
- `ACLK` in 1: clock, all logic on rising edge
- `ARESETN` in 1: synchronous active-low reset
- `AWVALID` in 1 / `AWREADY` out 1 / `AWADDR` in ADDR_W: write address channel
- `WVALID` in 1 / `WREADY` out 1 / `WDATA` in DATA_W: write data channel
- `BVALID` out 1 / `BREADY` in 1 / `BRESP` out 2: write response (00 OKAY, 10 SLVERR)
- `ARVALID` in 1 / `ARREADY` out 1 / `ARADDR` in ADDR_W: read address channel
- `RVALID` out 1 / `RREADY` in 1 / `RDATA` out DATA_W / `RRESP` out 2: read data channel

## Operation
- Address decode: `addr[1:0]` ignored. Offsets 0x0–0xC mapped; any address with `addr[31:4]` ≠ 0 is unmapped.
- 0x0 CTRL (W/R):
  - Writing bit0 = 1 while idle starts the engine.
  - bit0 always reads 0 (self-clearing); other bits read 0.
- 0x4 STATUS (RO): bit0 BUSY, bit1 DONE, others 0. Writes are ignored and return OKAY.
- 0x8 DATA_IN (RW): plain 32-bit register.
- 0xC DATA_OUT (RO): engine result. Writes are ignored and return OKAY.
- Engine:
  - States IDLE → RUN → IDLE.
  - Start clears DONE, sets BUSY, latches DATA_IN and loads a counter with LATENCY.
  - When the counter expires: DATA_OUT = byte-reverse(latched DATA_IN), BUSY = 0, DONE = 1.
  - A start while BUSY is ignored; the write still returns OKAY.
  - DONE stays set until the next start.
- Unmapped write: no register changes, BRESP = SLVERR.
- Unmapped read: RDATA = 0, RRESP = SLVERR.

## Timing
- Reset: AWREADY = WREADY = ARREADY = 1; BVALID = RVALID = 0; BRESP = RRESP = 00; RDATA = 0; all registers 0; engine IDLE.
- Write address and write data are accepted independently:
  - AWREADY drops once AW is captured; WREADY drops once W is captured.
  - Both are captured in the same or in different cycles.
- Register update and BVALID assertion occur in the cycle after the later of the AW and W handshakes.
- BVALID and BRESP hold until BREADY is high. AWREADY and WREADY return high the cycle after the B handshake.
- Read:
  - RVALID asserts the cycle after the AR handshake, with ARREADY low meanwhile.
  - RDATA and RRESP are sampled at the AR handshake and held stable until RREADY.
  - ARREADY returns high the cycle after the R handshake.
- Simultaneous read and write are both legal. Register state is updated before a same-cycle read sample is not taken: a read sampled in the update cycle returns the pre-update value.
- Engine timing:
  - BUSY = 1 from the cycle after the CTRL write commits.
  - DONE and DATA_OUT are valid exactly LATENCY cycles later.
- Reset mid-operation aborts any pending B/R response and any engine run; all state returns to reset values.

## Structure
- Package `top_soc_pkg`:
  - Register offsets: CTRL 0x0, STATUS 0x4, DATA_IN 0x8, DATA_OUT 0xC.
  - RESP constants: OKAY 2'b00, SLVERR 2'b10.
  - STATUS bit indices.
  - Engine state enum.
- Sub-module `soc_engine`: start/busy/done, counter and byte-reverse datapath.
- `top_soc` contains the AXI-Lite channel logic and the register file.

## Test plan
- Write 0x8 = 0x1234_5678, then read 0x8 → RDATA 0x1234_5678, RRESP 00; BRESP 00.
- Write 0x0 = 1, then immediately read 0x4 → 0x1 (BUSY). After LATENCY+2 cycles read 0x4 → 0x2 and read 0xC → 0x7856_3412.
- Write 0x0 = 1 while BUSY → BRESP 00; DONE timing is unchanged from the first start.
- Read 0x20 → RDATA 0, RRESP 10. Write 0x40 = 0xFFFF_FFFF → BRESP 10, and all registers are unchanged.
- Present W two cycles before AW, and hold BREADY/RREADY low for 3 cycles → no register update until both are captured; BVALID/RVALID and their data/response stay stable until accepted.
- Pulse ARESETN low during an engine run with BVALID pending → all outputs return to reset values; STATUS reads 0 afterwards.
